// File: rtl/game_pkg.sv
// Shared match-controller types: FSM state encoding, LFSR constants, score helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // One step of the right-shifting Galois LFSR.
   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
   endfunction

   // Scores are 4-bit and must never wrap back to zero.
   function automatic logic [3:0] score_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/game_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 0xB400), stepping every clk; entropy source for serves.
// Latency: new value every cycle; seed visible as soon as reset_n is low.
// Backpressure: none, never stalls.
// Ports: clk, reset_n (async active-low), q[15:0] current LFSR state.
module lfsr16
   import game_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   output logic [15:0] q
);

   // A Galois LFSR seeded non-zero can never reach the all-zero lock-up state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= LFSR_SEED;
      end else begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// Match controller: scores out_left/out_right, sequences serve/play/point/over, drives ball reset/entropy/speed.
// Latency: edge on out_* in PLAY -> score, state and ball_reset update on the next clk; all outputs registered.
// Backpressure: none; inputs are level signals sampled every cycle, edges outside PLAY (start outside IDLE/OVER) ignored.
// Ports: clk, reset_n (async active-low), start, out_left, out_right in;
//        ball_reset, entropy[4:0], speed[4:0] (signed), score_l[3:0], score_r[3:0], game_over, winner out.
module game_ctrl
   import game_pkg::*;
#(
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_CYCLES = 1000,
   parameter int POINT_CYCLES = 2000,
   parameter int RALLY_CYCLES = 4000,
   parameter int SPEED_INIT   = 4,
   parameter int SPEED_MAX    = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              out_left,
   input  logic              out_right,
   output logic              ball_reset,
   output logic [4:0]        entropy,
   output logic signed [4:0] speed,
   output logic [3:0]        score_l,
   output logic [3:0]        score_r,
   output logic              game_over,
   output logic              winner
);

   // Terminal counts for the shared phase counter; a zero-length phase still lasts one cycle.
   localparam logic [15:0] SERVE_LAST = 16'((SERVE_CYCLES > 0) ? SERVE_CYCLES - 1 : 0);
   localparam logic [15:0] POINT_LAST = 16'((POINT_CYCLES > 0) ? POINT_CYCLES - 1 : 0);
   localparam logic [15:0] RALLY_LAST = 16'((RALLY_CYCLES > 0) ? RALLY_CYCLES - 1 : 0);

   localparam logic signed [4:0] SPD_INIT = 5'(SPEED_INIT);
   localparam logic signed [4:0] SPD_MAX  = 5'(SPEED_MAX);
   localparam logic [3:0]        WIN      = 4'(WIN_SCORE);

   state_t      state;
   logic [15:0] cnt;
   logic        start_q;
   logic        left_q;
   logic        right_q;
   logic        start_rise;
   logic        left_rise;
   logic        right_rise;
   logic [15:0] lfsr_q;
   logic        unused_lfsr;

   lfsr16 u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .q       (lfsr_q)
   );

   // Only the low five bits feed the ball; the rest is pure LFSR state.
   assign entropy     = lfsr_q[4:0];
   assign unused_lfsr = ^lfsr_q[15:5];

   assign start_rise = start     & ~start_q;
   assign left_rise  = out_left  & ~left_q;
   assign right_rise = out_right & ~right_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         speed      <= SPD_INIT;
         score_l    <= '0;
         score_r    <= '0;
         ball_reset <= 1'b1;
         game_over  <= 1'b0;
         winner     <= 1'b0;
         start_q    <= 1'b0;
         left_q     <= 1'b0;
         right_q    <= 1'b0;
      end else begin
         // Edge registers track their inputs in every state so a level held
         // across a state change never looks like a fresh edge.
         start_q <= start;
         left_q  <= out_left;
         right_q <= out_right;

         case (state)
            IDLE: begin
               ball_reset <= 1'b1;
               if (start_rise) begin
                  state   <= SERVE;
                  cnt     <= '0;
                  score_l <= '0;
                  score_r <= '0;
                  speed   <= SPD_INIT;
               end
            end

            SERVE: begin
               ball_reset <= 1'b1;
               speed      <= SPD_INIT;
               if (cnt == SERVE_LAST) begin
                  state      <= PLAY;
                  cnt        <= '0;
                  ball_reset <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            PLAY: begin
               // A point ends the rally, so it outranks a coincident speed step.
               if (left_rise || right_rise) begin
                  state      <= POINT;
                  cnt        <= '0;
                  ball_reset <= 1'b1;
                  // Both edges together is a dead ball: re-serve, nobody scores.
                  if (right_rise && !left_rise) score_l <= score_inc(score_l);
                  if (left_rise && !right_rise) score_r <= score_inc(score_r);
               end else if (cnt == RALLY_LAST) begin
                  cnt <= '0;
                  if (speed < SPD_MAX) speed <= speed + 5'sd1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            POINT: begin
               ball_reset <= 1'b1;
               if (cnt == POINT_LAST) begin
                  cnt <= '0;
                  if (score_l == WIN || score_r == WIN) begin
                     state     <= OVER;
                     game_over <= 1'b1;
                     winner    <= (score_r == WIN);
                  end else begin
                     state <= SERVE;
                     speed <= SPD_INIT;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            OVER: begin
               ball_reset <= 1'b1;
               game_over  <= 1'b1;
               if (start_rise) begin
                  state     <= SERVE;
                  cnt       <= '0;
                  score_l   <= '0;
                  score_r   <= '0;
                  speed     <= SPD_INIT;
                  game_over <= 1'b0;
                  winner    <= 1'b0;
               end
            end

            default: begin
               state      <= IDLE;
               cnt        <= '0;
               ball_reset <= 1'b1;
            end
         endcase
      end
   end

endmodule
